// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Single-outstanding instruction fetch stage. Issues one request
//            to instruction memory, holds the returned word for decode, and
//            applies control-flow redirects, killing an in-flight request
//            whose address has gone stale.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_base,
    input  logic [31:0] redirect_imm,
    input  logic        redirect_jalr,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [31:0] C_PC_STEP = 32'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        misalign_err_q, misalign_err_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic [31:0] w_target_sum;
    logic [31:0] w_target;
    logic        w_target_misaligned;

    // Redirect target: base + imm, with bit 0 dropped for jalr.
    always_comb begin
        w_target_sum        = redirect_base + redirect_imm;
        w_target            = {w_target_sum[31:1], w_target_sum[0] & ~redirect_jalr};
        w_target_misaligned = (w_target[1:0] != 2'b00);
    end

    // Next-state logic and output decode.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        kill_d         = kill_q;
        misalign_err_d = misalign_err_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;

        imem_req   = (state_q == ST_REQ);
        imem_addr  = pc_q;
        inst_valid = (state_q == ST_HOLD) && !redirect;

        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    if (w_target_misaligned) begin
                        misalign_err_d = 1'b1;
                        state_d        = ST_ERR;
                    end else begin
                        pc_d    = w_target;
                        // A same-cycle ack retires the stale request, so only
                        // a still-pending request needs killing.
                        kill_d  = !imem_ack;
                        state_d = ST_REQ;
                    end
                end else if (imem_ack) begin
                    if (kill_q) begin
                        // Returning word belongs to the pre-redirect address.
                        kill_d = 1'b0;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + C_PC_STEP;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    if (w_target_misaligned) begin
                        misalign_err_d = 1'b1;
                        state_d        = ST_ERR;
                    end else begin
                        pc_d    = w_target;
                        state_d = ST_REQ;
                    end
                end else if (inst_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_REQ;
            pc_q           <= RESET_PC;
            kill_q         <= 1'b0;
            misalign_err_q <= 1'b0;
            inst_q         <= 32'd0;
            inst_pc_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            kill_q         <= kill_d;
            misalign_err_q <= misalign_err_d;
            inst_q         <= inst_d;
            inst_pc_q      <= inst_pc_d;
        end
    end

    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign misalign_err = misalign_err_q;

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 imem_req  output  1  SHALL flag a fetch request to instruction memory.
REQ-005 imem_addr  output  32  SHALL carry the fetch byte address.
REQ-006 imem_ack  input  1  SHALL flag that imem_rdata is valid for the current request.
REQ-007 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-008 inst_valid  output  1  SHALL flag that inst/inst_pc hold a valid instruction for decode and immediate generation.
REQ-009 inst_ready  input  1  SHALL flag that decode accepts the instruction this cycle.
REQ-010 inst  output  32  SHALL carry the held instruction word.
REQ-011 inst_pc  output  32  SHALL carry the held instruction's address.
REQ-012 redirect  input  1  SHALL request a control-flow change (taken branch, jal, jalr).
REQ-013 redirect_base  input  32  SHALL carry the target base (branch/jal: PC; jalr: rs1).
REQ-014 redirect_imm  input  32  SHALL carry the sign-extended immediate.
REQ-015 redirect_jalr  input  1  SHALL flag that target bit 0 is cleared.
REQ-016 misalign_err  output  1  SHALL flag a misaligned redirect target; sticky.

Function
REQ-017 States SHALL be REQ (waiting on imem_ack), HOLD (instruction held), ERR (halted).
REQ-018 Transfer SHALL occur in a cycle with inst_valid=1 and inst_ready=1.
REQ-019 imem_req SHALL be 1 exactly in REQ; imem_addr SHALL equal the internal pc register in REQ.
REQ-020 REQ + imem_ack + no redirect + kill=0: latch imem_rdata into inst and pc into inst_pc, pc <= pc+4, go HOLD.
REQ-021 HOLD + transfer + no redirect: go REQ; the next fetch uses the already-incremented pc.
REQ-022 HOLD + no transfer + no redirect: inst/inst_pc SHALL remain stable.
REQ-023 inst_valid SHALL equal (state==HOLD) AND NOT redirect; redirect masks it the same cycle.
REQ-024 Target SHALL be redirect_base+redirect_imm mod 2^32, bit 0 forced to 0 when redirect_jalr=1.
REQ-025 On redirect with target[1:0]==0, in any non-ERR state: pc <= target, held instruction discarded, go REQ.
REQ-026 Redirect in REQ with imem_ack=0: kill flag SHALL set, since the outstanding request stays live with its old address.
REQ-027 In REQ with kill=1, the next imem_ack SHALL be discarded, kill cleared, and state stays REQ with imem_addr = redirect target.
REQ-028 Redirect in REQ with imem_ack=1 in the same cycle: the ack'd word SHALL be discarded, kill stays 0, and the next cycle requests the target.
REQ-029 Redirect with target[1:0]!=0: misalign_err <= 1, go ERR; pc is unchanged.
REQ-030 In ERR, imem_req=0, inst_valid=0, and redirect and imem_ack SHALL be ignored until rst.
REQ-031 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
REQ-032 A held instruction SHALL never be duplicated or skipped; each ack'd non-killed word SHALL be transferred once unless a redirect discards it.

Reset
REQ-033 While rst=1 on a clock edge: state <= REQ, pc <= RESET_PC, kill <= 0, misalign_err <= 0, inst <= 0, inst_pc <= 0.
REQ-034 rst SHALL override redirect and imem_ack in the same cycle.
REQ-035 Mid-operation reset SHALL discard any held or outstanding fetch.
REQ-036 In the first cycle after reset release: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-037 Sequential flow: reset, ack every request with word=addr, inst_ready=1 -> inst_pc sequence 0,4,8,12; one transfer per 2 cycles.
REQ-038 Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, imem_req=0; ready=1 -> one transfer, then fetch of pc+4.
REQ-039 Killed fetch: in REQ at 0x10, redirect base 0x10, imm 0x20, ack 3 cycles later -> that word discarded; next imem_addr=0x30, and 0x30 is delivered.
REQ-040 jalr: base 0x103, imm 0, jalr=1 -> target 0x102, misalign_err=1, ERR; later acks are ignored, and rst clears the error.
REQ-041 Wrap: RESET_PC=32'hFFFF_FFFC, one fetch -> next imem_addr=0x0000_0000.
REQ-042 Redirect in HOLD together with inst_ready=1 -> inst_valid=0 that cycle, no transfer counted, next imem_addr=target.
